mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port synchronous unified memory between the RV32I instruction-fetch (IF) port and the load/store (LS) port. It decides the grant in the request cycle and drives the memory port combinationally from the winner. It tracks the owner of the access in flight so that the 1-cycle-latency read data returns to the correct requester. It sits between the core and the memory, in the place of the separate instruction-memory path.

---
 rtl/rv_mem_pkg.sv | 13 +
 rtl/arb_starve_cnt.sv | 29 ++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared owner encoding and default widths for the unified memory port
package rv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } own_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of consecutive IF stall cycles
module arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_force = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS arbiter for one single-port memory with 1-cycle read return
// Optional IF starvation guard: MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_add,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_add,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_be,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_add,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  own_e resp_own, resp_own_nxt;
  logic if_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_if_req (i_if_req),
    .i_if_gnt (o_if_gnt),
    .o_force  (if_force)
  );
`else
  assign if_force = (MAX_WAIT < 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resp_own <= OWN_NONE;
    end else begin
      resp_own <= resp_own_nxt;
    end
  end

  // Grants are the only source of memory activity; reset masks both.
  always_comb begin
    o_if_gnt = 1'b0;
    o_ls_gnt = 1'b0;
    if (!i_rst) begin
      if (i_if_req && (if_force || !i_ls_req)) begin
        o_if_gnt = 1'b1;
      end else if (i_ls_req) begin
        o_ls_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_add    = '0;
    o_mem_wdata  = '0;
    o_mem_be     = '0;
    resp_own_nxt = OWN_NONE;
    if (o_ls_gnt) begin
      o_mem_en     = 1'b1;
      o_mem_we     = i_ls_we;
      o_mem_add    = i_ls_add;
      o_mem_wdata  = i_ls_wdata;
      o_mem_be     = i_ls_be;
      resp_own_nxt = i_ls_we ? OWN_NONE : OWN_LS;
    end else if (o_if_gnt) begin
      o_mem_en     = 1'b1;
      o_mem_add    = i_if_add;
      o_mem_be     = '1;
      resp_own_nxt = OWN_IF;
    end
  end

  // Read data is steered by who owned last cycle's access, not by this cycle's grant.
  assign o_if_rvalid = (resp_own == OWN_IF);
  assign o_ls_rvalid = (resp_own == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_add = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_add = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_add, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:63];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (if_req),
    .i_if_add    (if_add),
    .o_if_gnt    (if_gnt),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .i_ls_req    (ls_req),
    .i_ls_we     (ls_we),
    .i_ls_add    (ls_add),
    .i_ls_wdata  (ls_wdata),
    .i_ls_be     (ls_be),
    .o_ls_gnt    (ls_gnt),
    .o_ls_rvalid (ls_rvalid),
    .o_ls_rdata  (ls_rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_add   (mem_add),
    .o_mem_wdata (mem_wdata),
    .o_mem_be    (mem_be),
    .i_mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_add[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_add[7:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit if_pending;
    bit exp_if;

    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_rvalid", {31'b0, if_rvalid}, 0);
    check("rst_ls_rvalid", {31'b0, ls_rvalid}, 0);
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_gnt", {30'b0, if_gnt, ls_gnt}, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // idle outputs
    @(negedge clk);
    check("idle_mem", {mem_en, mem_we, mem_be, 26'b0} | mem_add | mem_wdata, 0);
    next_cycle();

    // IF only, back-to-back
    for (int k = 0; k < 50; k++) begin
      if_req = 1'b1;
      if_add = 32'(4 * k);
      @(negedge clk);
      check("ifo_gnt", {31'b0, if_gnt}, 1);
      check("ifo_add", mem_add, 32'(4 * k));
      check("ifo_drive", {27'b0, mem_we, mem_be}, 32'h0000000F);
      check("ifo_wdata", mem_wdata, 0);
      if (k > 0) begin
        check("ifo_rvalid", {31'b0, if_rvalid}, 1);
        check("ifo_rdata", if_rdata, 32'h1000 + 32'(k - 1));
      end
      check("ifo_ls_rvalid", {31'b0, ls_rvalid}, 0);
      next_cycle();
    end
    if_req = 1'b0;
    @(negedge clk);
    check("ifo_last_rvalid", {31'b0, if_rvalid}, 1);
    check("ifo_last_rdata", if_rdata, 32'h1031);
    check("ifo_last_mem_en", {31'b0, mem_en}, 0);
    next_cycle();
    @(negedge clk);
    check("ifo_tail_rvalid", {31'b0, if_rvalid}, 0);
    next_cycle();

    // contention: LS read wins, IF next
    if_req = 1'b1; if_add = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_add = 32'h80; ls_be = 4'hF;
    @(negedge clk);
    check("ct_ls_gnt", {31'b0, ls_gnt}, 1);
    check("ct_if_gnt0", {31'b0, if_gnt}, 0);
    check("ct_add_ls", mem_add, 32'h80);
    check("ct_we", {31'b0, mem_we}, 0);
    next_cycle();
    ls_req = 1'b0;
    @(negedge clk);
    check("ct_if_gnt1", {31'b0, if_gnt}, 1);
    check("ct_add_if", mem_add, 32'h20);
    check("ct_ls_rvalid", {31'b0, ls_rvalid}, 1);
    check("ct_ls_rdata", ls_rdata, 32'h1020);
    check("ct_if_rvalid0", {31'b0, if_rvalid}, 0);
    check("ct_if_rdata0", if_rdata, 0);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("ct_if_rvalid1", {31'b0, if_rvalid}, 1);
    check("ct_if_rdata1", if_rdata, 32'h1008);
    check("ct_ls_rvalid1", {31'b0, ls_rvalid}, 0);
    check("ct_ls_rdata1", ls_rdata, 0);
    next_cycle();

    // LS partial write, then IF read of merged word
    ls_req = 1'b1; ls_we = 1'b1; ls_add = 32'h40; ls_wdata = 32'hDEADBEEF; ls_be = 4'b0011;
    @(negedge clk);
    check("wr_gnt", {31'b0, ls_gnt}, 1);
    check("wr_we", {31'b0, mem_we}, 1);
    check("wr_be", {28'b0, mem_be}, 32'h3);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    ls_req = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; if_add = 32'h40;
    @(negedge clk);
    check("wr_no_rvalid", {30'b0, if_rvalid, ls_rvalid}, 0);
    check("wr_rd_gnt", {31'b0, if_gnt}, 1);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("wr_rd_rvalid", {31'b0, if_rvalid}, 1);
    check("wr_rd_data", if_rdata, 32'h0000BEEF);
    next_cycle();

    // reset with IF response in flight
    if_req = 1'b1; if_add = 32'h10;
    @(negedge clk);
    check("rm_gnt", {31'b0, if_gnt}, 1);
    #2 rst = 1'b1;
    #1;
    check("rm_gnt_forced", {30'b0, if_gnt, ls_gnt}, 0);
    check("rm_mem_en_forced", {31'b0, mem_en}, 0);
    check("rm_rvalid_in_rst", {31'b0, if_rvalid}, 0);
    if_req = 1'b0;
    next_cycle();
    check("rm_rvalid_after_edge", {31'b0, if_rvalid}, 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    check("rm_rvalid_post", {30'b0, if_rvalid, ls_rvalid}, 0);
    next_cycle();

    // LS hogging the port with IF pending
    if_pending = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_add = 32'h0; ls_be = 4'hF;
      if_req = if_pending; if_add = 32'h4;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (i == 4);
`else
      exp_if = 1'b0;
`endif
      @(negedge clk);
      check("sv_if_gnt", {31'b0, if_gnt}, {31'b0, exp_if});
      check("sv_ls_gnt", {31'b0, ls_gnt}, {31'b0, ~exp_if});
      next_cycle();
      if (exp_if) if_pending = 1'b0;
    end
    ls_req = 1'b0; if_req = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
